lvds_tx_mapper: RTL and testbench

Pixel-domain front end for the OVIDEO-based 7:1 LVDS (FPD-Link/OpenLDI) transmitter. It accepts one RGB888 pixel plus HS/VS/DE per PCLK cycle and maps them onto 7-bit lane words for up to four data lanes and the clock lane. Each word is presented directly to the D0..D6 inputs of one OVIDEO instance per lane. A start-up sequencer holds the data lanes quiet until the receiver has had time to lock and a frame boundary has been seen.

---
 rtl/lvds_pkg.sv | 24 ++
 rtl/lvds_bar_gen.sv | 50 +++++
 rtl/lvds_tx_mapper.sv | 171 +++++++++++++++++
 tb/tb_lvds_tx_mapper.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_pkg.sv
// rtl/lvds_pkg.sv - shared types and constants for the LVDS transmit mapper
package lvds_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    RUN     = 2'd2
  } state_e;

  typedef logic [6:0] lane_word_t;

  // D0..D6 = 1,1,0,0,0,1,1 : four high, three low bit times around the pixel
  localparam lane_word_t CLK_WORD = 7'b1100011;

  // {R,G,B} full-scale flags per bar index: W, Y, C, G, M, R, B, K
  localparam logic [7:0][2:0] BAR_TABLE = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    return BAR_TABLE[idx];
  endfunction

endpackage

// File: rtl/lvds_bar_gen.sv
// rtl/lvds_bar_gen.sv - eight vertical colour bars keyed to the active-pixel position
module lvds_bar_gen
  import lvds_pkg::*;
#(
  parameter int BAR_W = 128
) (
  input  logic       pclk_i,
  input  logic       rst_i,
  input  logic       de_i,
  output logic [7:0] r_o,
  output logic [7:0] g_o,
  output logic [7:0] b_o
);

  logic [11:0] pix_cnt_q, pix_cnt_d;
  logic [2:0]  bar_q, bar_d;
  logic [2:0]  rgb;

  // Count pixels inside the current bar; blanking returns to the left edge
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    bar_d     = bar_q;
    if (!de_i) begin
      pix_cnt_d = '0;
      bar_d     = '0;
    end else if (pix_cnt_q == 12'(BAR_W - 1)) begin
      pix_cnt_d = '0;
      bar_d     = bar_q + 3'd1;
    end else begin
      pix_cnt_d = pix_cnt_q + 12'd1;
    end
  end

  // Pixel and bar counter registers
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      pix_cnt_q <= '0;
      bar_q     <= '0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      bar_q     <= bar_d;
    end
  end

  assign rgb = bar_rgb(bar_q);
  assign r_o = {8{rgb[2]}};
  assign g_o = {8{rgb[1]}};
  assign b_o = {8{rgb[0]}};

endmodule

// File: rtl/lvds_tx_mapper.sv
// rtl/lvds_tx_mapper.sv - RGB888 to 7:1 LVDS lane words with start-up sequencer; LVDS_TX_PATTERN_EN adds colour bars
module lvds_tx_mapper
  import lvds_pkg::*;
#(
  parameter string FORMAT      = "VESA",
  parameter int    LANES       = 4,
  parameter int    IDLE_CYCLES = 1024,
  parameter int    BAR_W       = 128
) (
  input  logic       PCLK,
  input  logic       RESET,
  input  logic       I_HS,
  input  logic       I_VS,
  input  logic       I_DE,
  input  logic [7:0] I_R,
  input  logic [7:0] I_G,
  input  logic [7:0] I_B,
  input  logic       I_PAT_SEL,
  output logic [6:0] O_CLK,
  output logic [6:0] O_LANE0,
  output logic [6:0] O_LANE1,
  output logic [6:0] O_LANE2,
  output logic [6:0] O_LANE3,
  output logic       O_ACTIVE
);

  // 18 bpp links only carry the upper six bits, which is exactly the JEIDA L0-L2 layout
  localparam bit JEIDA_MAP = (FORMAT == "JEIDA") || (LANES == 3);
  localparam int CNT_W     = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

  logic [7:0] pix_r, pix_g, pix_b;

`ifdef LVDS_TX_PATTERN_EN
  logic [7:0] bar_r, bar_g, bar_b;

  lvds_bar_gen #(.BAR_W(BAR_W)) u_bar_gen (
    .pclk_i (PCLK),
    .rst_i  (RESET),
    .de_i   (I_DE),
    .r_o    (bar_r),
    .g_o    (bar_g),
    .b_o    (bar_b)
  );

  assign pix_r = I_PAT_SEL ? bar_r : I_R;
  assign pix_g = I_PAT_SEL ? bar_g : I_G;
  assign pix_b = I_PAT_SEL ? bar_b : I_B;
`else
  logic unused_cfg;
  assign unused_cfg = I_PAT_SEL ^ (BAR_W == 0);
  assign pix_r = I_R;
  assign pix_g = I_G;
  assign pix_b = I_B;
`endif

  logic       s1_hs_q, s1_vs_q, s1_de_q, vs_prev_q;
  logic [7:0] s1_r_q, s1_g_q, s1_b_q;

  // Stage 1: capture syncs and pixel; keep the previous VS for frame-edge detection
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      s1_hs_q   <= 1'b0;
      s1_vs_q   <= 1'b0;
      s1_de_q   <= 1'b0;
      s1_r_q    <= '0;
      s1_g_q    <= '0;
      s1_b_q    <= '0;
      vs_prev_q <= 1'b0;
    end else begin
      s1_hs_q   <= I_HS;
      s1_vs_q   <= I_VS;
      s1_de_q   <= I_DE;
      s1_r_q    <= pix_r;
      s1_g_q    <= pix_g;
      s1_b_q    <= pix_b;
      vs_prev_q <= s1_vs_q;
    end
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vs_fall;

  assign vs_fall = vs_prev_q & ~s1_vs_q;

  // Sequencer: clock-only lock time, then wait for the end of a vertical sync pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cnt_q == CNT_W'(IDLE_CYCLES - 1)) state_d = WAIT_VS;
        else                                  cnt_d   = cnt_q + CNT_W'(1);
      end
      WAIT_VS: if (vs_fall) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and lock-time counter
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic       m_de;
  logic [7:0] m_r, m_g, m_b;
  lane_word_t l0_d, l1_d, l2_d, l3_d;

  // Stage 2 mapping: syncs only while waiting for a frame, everything once running
  always_comb begin
    m_de = (state_q == RUN) & s1_de_q;
    m_r  = (state_q == RUN) ? s1_r_q : 8'h00;
    m_g  = (state_q == RUN) ? s1_g_q : 8'h00;
    m_b  = (state_q == RUN) ? s1_b_q : 8'h00;
    if (JEIDA_MAP) begin
      l0_d = {m_g[2], m_r[7:2]};
      l1_d = {m_b[3:2], m_g[7:3]};
      l2_d = {m_de, s1_vs_q, s1_hs_q, m_b[7:4]};
      l3_d = {1'b0, m_b[1:0], m_g[1:0], m_r[1:0]};
    end else begin
      l0_d = {m_g[0], m_r[5:0]};
      l1_d = {m_b[1:0], m_g[5:1]};
      l2_d = {m_de, s1_vs_q, s1_hs_q, m_b[5:2]};
      l3_d = {1'b0, m_b[7:6], m_g[7:6], m_r[7:6]};
    end
    if (LANES == 3) l3_d = '0;
    if (state_q == IDLE) begin
      l0_d = '0;
      l1_d = '0;
      l2_d = '0;
      l3_d = '0;
    end
  end

  lane_word_t clk_q, l0_q, l1_q, l2_q, l3_q;
  logic       active_q;

  // Stage 2 output registers feeding the serializers directly
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      clk_q    <= '0;
      l0_q     <= '0;
      l1_q     <= '0;
      l2_q     <= '0;
      l3_q     <= '0;
      active_q <= 1'b0;
    end else begin
      clk_q    <= CLK_WORD;
      l0_q     <= l0_d;
      l1_q     <= l1_d;
      l2_q     <= l2_d;
      l3_q     <= l3_d;
      active_q <= (state_q == RUN);
    end
  end

  assign O_CLK    = clk_q;
  assign O_LANE0  = l0_q;
  assign O_LANE1  = l1_q;
  assign O_LANE2  = l2_q;
  assign O_LANE3  = l3_q;
  assign O_ACTIVE = active_q;

endmodule

// File: tb/tb_lvds_tx_mapper.sv
// tb/tb_lvds_tx_mapper.sv - directed self-checking bench for lvds_tx_mapper
`timescale 1ns/1ps
module tb_lvds_tx_mapper;

`ifdef LVDS_TX_PATTERN_EN
  localparam int NDUT = 4;
`else
  localparam int NDUT = 3;
`endif

  logic       PCLK = 1'b0;
  logic       RESET;
  logic       hs, vs, de, pat;
  logic [7:0] r, g, b;
  logic [6:0] ck [NDUT];
  logic [6:0] l0 [NDUT];
  logic [6:0] l1 [NDUT];
  logic [6:0] l2 [NDUT];
  logic [6:0] l3 [NDUT];
  logic       act [NDUT];
  int errors = 0;
  int checks = 0;

  always #5 PCLK = ~PCLK;

  lvds_tx_mapper #(.FORMAT("VESA"), .LANES(4), .IDLE_CYCLES(4), .BAR_W(128)) dut_v (
    .PCLK(PCLK), .RESET(RESET), .I_HS(hs), .I_VS(vs), .I_DE(de),
    .I_R(r), .I_G(g), .I_B(b), .I_PAT_SEL(pat),
    .O_CLK(ck[0]), .O_LANE0(l0[0]), .O_LANE1(l1[0]), .O_LANE2(l2[0]), .O_LANE3(l3[0]),
    .O_ACTIVE(act[0]));

  lvds_tx_mapper #(.FORMAT("JEIDA"), .LANES(4), .IDLE_CYCLES(4), .BAR_W(128)) dut_j (
    .PCLK(PCLK), .RESET(RESET), .I_HS(hs), .I_VS(vs), .I_DE(de),
    .I_R(r), .I_G(g), .I_B(b), .I_PAT_SEL(pat),
    .O_CLK(ck[1]), .O_LANE0(l0[1]), .O_LANE1(l1[1]), .O_LANE2(l2[1]), .O_LANE3(l3[1]),
    .O_ACTIVE(act[1]));

  lvds_tx_mapper #(.FORMAT("VESA"), .LANES(3), .IDLE_CYCLES(4), .BAR_W(128)) dut_3 (
    .PCLK(PCLK), .RESET(RESET), .I_HS(hs), .I_VS(vs), .I_DE(de),
    .I_R(r), .I_G(g), .I_B(b), .I_PAT_SEL(pat),
    .O_CLK(ck[2]), .O_LANE0(l0[2]), .O_LANE1(l1[2]), .O_LANE2(l2[2]), .O_LANE3(l3[2]),
    .O_ACTIVE(act[2]));

`ifdef LVDS_TX_PATTERN_EN
  lvds_tx_mapper #(.FORMAT("VESA"), .LANES(4), .IDLE_CYCLES(4), .BAR_W(2)) dut_p (
    .PCLK(PCLK), .RESET(RESET), .I_HS(hs), .I_VS(vs), .I_DE(de),
    .I_R(r), .I_G(g), .I_B(b), .I_PAT_SEL(pat),
    .O_CLK(ck[3]), .O_LANE0(l0[3]), .O_LANE1(l1[3]), .O_LANE2(l2[3]), .O_LANE3(l3[3]),
    .O_ACTIVE(act[3]));
`endif

  function automatic logic [27:0] lanes_of(input int i);
    return {l3[i], l2[i], l1[i], l0[i]};
  endfunction

  task automatic step();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic set_pix(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                         input logic h, input logic v, input logic d);
    r = rr; g = gg; b = bb; hs = h; vs = v; de = d;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    set_pix(8'hA5, 8'h3C, 8'hF0, 1'b1, 1'b1, 1'b1);
    repeat (3) step();
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if ({act[i], ck[i], lanes_of(i)} !== 36'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %h expected 0", i, {act[i], ck[i], lanes_of(i)});
      end
    end
  endtask

  // Releases reset at a negedge and walks IDLE -> WAIT_VS -> RUN; VS dips during IDLE are ignored
  task automatic test_bringup(input string tag);
    logic [9:1] vs_seq;
    logic [6:0] exp_l2;
    vs_seq = 9'b000111010;
    set_pix(8'hA5, 8'h3C, 8'hF0, 1'b1, vs_seq[1], 1'b1);
    RESET = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      vs = vs_seq[n];
      step();
      if (n == 1) begin
        for (int i = 0; i < NDUT; i++) begin
          checks++;
          if (ck[i] !== 7'b1100011) begin
            errors++;
            $display("FAIL %s_clk_word dut%0d: got %b expected 1100011", tag, i, ck[i]);
          end
        end
      end
      if (n <= 4) begin
        for (int i = 0; i < NDUT; i++) begin
          checks++;
          if (lanes_of(i) !== 28'h0 || act[i] !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_quiet cycle%0d dut%0d: got lanes %h act %b expected 0", tag, n, i, lanes_of(i), act[i]);
          end
        end
      end else if (n <= 8) begin
        exp_l2 = (n <= 7) ? 7'h30 : 7'h10;
        for (int i = 0; i < NDUT; i++) begin
          checks++;
          if (lanes_of(i) !== {7'h00, exp_l2, 14'h0} || act[i] !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait_vs cycle%0d dut%0d: got lanes %h act %b expected %h act 0", tag, n, i, lanes_of(i), act[i], {7'h00, exp_l2, 14'h0});
          end
        end
      end else begin
        for (int i = 0; i < NDUT; i++) begin
          checks++;
          if (act[i] !== 1'b1) begin
            errors++;
            $display("FAIL %s_active_rise dut%0d: got %b expected 1", tag, i, act[i]);
          end
        end
        checks++;
        if (lanes_of(0) !== {7'h32, 7'h5C, 7'h1E, 7'h25}) begin
          errors++;
          $display("FAIL %s_first_vesa: got %h expected %h", tag, lanes_of(0), {7'h32, 7'h5C, 7'h1E, 7'h25});
        end
        checks++;
        if (lanes_of(1) !== {7'h01, 7'h5F, 7'h07, 7'h69}) begin
          errors++;
          $display("FAIL %s_first_jeida: got %h expected %h", tag, lanes_of(1), {7'h01, 7'h5F, 7'h07, 7'h69});
        end
        checks++;
        if (lanes_of(2) !== {7'h00, 7'h5F, 7'h07, 7'h69}) begin
          errors++;
          $display("FAIL %s_first_18bpp: got %h expected %h", tag, lanes_of(2), {7'h00, 7'h5F, 7'h07, 7'h69});
        end
      end
    end
  endtask

  task automatic test_map(input string tag, input logic [7:0] rr, input logic [7:0] gg,
                          input logic [7:0] bb, input logic h, input logic v, input logic d,
                          input logic [27:0] ev, input logic [27:0] ej);
    set_pix(rr, gg, bb, h, v, d);
    step();
    step();
    checks++;
    if (lanes_of(0) !== ev) begin
      errors++;
      $display("FAIL %s_vesa: got %h expected %h", tag, lanes_of(0), ev);
    end
    checks++;
    if (lanes_of(1) !== ej) begin
      errors++;
      $display("FAIL %s_jeida: got %h expected %h", tag, lanes_of(1), ej);
    end
    checks++;
    if (lanes_of(2) !== {7'h00, ej[20:0]}) begin
      errors++;
      $display("FAIL %s_18bpp: got %h expected %h", tag, lanes_of(2), {7'h00, ej[20:0]});
    end
    checks++;
    if (act[0] !== 1'b1) begin
      errors++;
      $display("FAIL %s_still_active: got %b expected 1", tag, act[0]);
    end
  endtask

  task automatic test_back_to_back();
    set_pix(8'hA5, 8'h3C, 8'hF0, 1'b0, 1'b0, 1'b1);
    step();
    set_pix(8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 1'b0);
    step();
    checks++;
    if (lanes_of(0) !== {7'h32, 7'h4C, 7'h1E, 7'h25}) begin
      errors++;
      $display("FAIL b2b_first: got %h expected %h", lanes_of(0), {7'h32, 7'h4C, 7'h1E, 7'h25});
    end
    set_pix(8'hA5, 8'h3C, 8'hF0, 1'b0, 1'b0, 1'b1);
    step();
    checks++;
    if (lanes_of(0) !== {7'h10, 7'h35, 7'h5A, 7'h12}) begin
      errors++;
      $display("FAIL b2b_second_vesa: got %h expected %h", lanes_of(0), {7'h10, 7'h35, 7'h5A, 7'h12});
    end
    checks++;
    if (lanes_of(1) !== {7'h22, 7'h35, 7'h26, 7'h44}) begin
      errors++;
      $display("FAIL b2b_second_jeida: got %h expected %h", lanes_of(1), {7'h22, 7'h35, 7'h26, 7'h44});
    end
  endtask

`ifdef LVDS_TX_PATTERN_EN
  // VESA lanes for a full-scale bar colour with DE=1, HS=VS=0
  function automatic logic [27:0] vesa_bar(input logic [2:0] c);
    logic rb, gb, bb;
    rb = c[2]; gb = c[1]; bb = c[0];
    return {1'b0, bb, bb, gb, gb, rb, rb,
            3'b100, {4{bb}},
            bb, bb, {5{gb}},
            gb, {6{rb}}};
  endfunction

  task automatic test_pattern();
    logic [2:0]  bar_tab [8];
    logic [27:0] exp;
    bar_tab = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    pat = 1'b1;
    set_pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    for (int j = 0; j <= 18; j++) begin
      de = (j < 18);
      step();
      if (j >= 1) begin
        exp = vesa_bar(bar_tab[((j - 1) / 2) % 8]);
        checks++;
        if (lanes_of(3) !== exp) begin
          errors++;
          $display("FAIL pattern_bar px%0d: got %h expected %h", j - 1, lanes_of(3), exp);
        end
      end
    end
    for (int m = 0; m <= 3; m++) begin
      de = (m < 3);
      step();
      if (m >= 1) begin
        exp = vesa_bar(bar_tab[(m - 1) / 2]);
        checks++;
        if (lanes_of(3) !== exp) begin
          errors++;
          $display("FAIL pattern_restart px%0d: got %h expected %h", m - 1, lanes_of(3), exp);
        end
      end
    end
    pat = 1'b0;
  endtask
`endif

  task automatic test_mid_reset();
    set_pix(8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b1);
    step();
    @(posedge PCLK);
    #2;
    RESET = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if ({act[i], ck[i], lanes_of(i)} !== 36'h0) begin
        errors++;
        $display("FAIL async_reset dut%0d: got %h expected 0", i, {act[i], ck[i], lanes_of(i)});
      end
    end
    @(negedge PCLK);
    step();
    test_bringup("rebringup");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    pat   = 1'b0;
    set_pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_bringup("bringup");
    test_map("pix_a5", 8'hA5, 8'h3C, 8'hF0, 1'b0, 1'b0, 1'b1,
             {7'h32, 7'h4C, 7'h1E, 7'h25}, {7'h01, 7'h4F, 7'h07, 7'h69});
    test_map("pix_12", 8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 1'b0,
             {7'h10, 7'h35, 7'h5A, 7'h12}, {7'h22, 7'h35, 7'h26, 7'h44});
    test_map("pix_white", 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1,
             {7'h3F, 7'h4F, 7'h7F, 7'h7F}, {7'h3F, 7'h4F, 7'h7F, 7'h7F});
    test_back_to_back();
`ifdef LVDS_TX_PATTERN_EN
    test_pattern();
`endif
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
